// File: rtl/shift_reg_pkg.sv
// Shared constants and index helpers for the shift-register bank.
// Pure definitions: no logic, no latency, no flow control.
package shift_reg_pkg;

  localparam logic DIR_UP   = 1'b0;  // stage j -> j+1, input at stage 0
  localparam logic DIR_DOWN = 1'b1;  // stage j+1 -> j, input at stage DEPTH-1

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  // Bit position of (lane, stage) in the lane-major output vector.
  function automatic int lane_idx(input int lane, input int stage, input int depth);
    return depth * lane + stage;
  endfunction

endpackage

// File: rtl/shift_lane.sv
// One bit lane of DEPTH stages with parallel load, bidirectional shift and rotate.
// State updates on the clock edge; no flow control, load has priority over shift.
module shift_lane
  import shift_reg_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             load,
  input  logic [DEPTH-1:0] load_vec,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             rotate,
  output logic [DEPTH-1:0] q
);

  logic up_in;
  logic down_in;

  // In rotate mode the input stage takes whichever end stage would be discarded.
  assign up_in   = rotate ? q[DEPTH-1] : ser_in;
  assign down_in = rotate ? q[0]       : ser_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_vec;
    end else if (shift_en) begin
      if (dir == DIR_UP) begin
        q <= {q[DEPTH-2:0], up_in};
      end else begin
        q <= {down_in, q[DEPTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/shift_reg_bank.sv
// WIDTH-lane shift-register bank with fill tracking and transposed/raw output views.
// Outputs register the pre-edge stage array (1 cycle latency); no backpressure.
module shift_reg_bank
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en,
  input  logic                   dir,
  input  logic                   rotate,
  input  logic                   load,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   out_en,
  output logic [WIDTH*DEPTH-1:0] data_o,
  output logic [WIDTH*DEPTH-1:0] ind,
  output logic [CNT_W-1:0]       fill,
  output logic                   full
);

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

  logic [DEPTH-1:0]       lane_q   [WIDTH];
  logic [DEPTH-1:0]       lane_ld  [WIDTH];
  logic [WIDTH*DEPTH-1:0] lane_view;
  logic [WIDTH*DEPTH-1:0] stage_view;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    for (genvar j = 0; j < DEPTH; j++) begin : g_stage
      assign lane_ld[i][j]                    = load_data[WIDTH*j+i];
      assign stage_view[WIDTH*j+i]            = lane_q[i][j];
      assign lane_view[lane_idx(i, j, DEPTH)] = lane_q[i][j];
    end

    shift_lane #(
      .DEPTH(DEPTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ser_in   (data_i[i]),
      .load     (load),
      .load_vec (lane_ld[i]),
      .shift_en (shift_en),
      .dir      (dir),
      .rotate   (rotate),
      .q        (lane_q[i])
    );
  end

  // Rotation only recirculates existing stages, so it never changes the fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if (load) begin
      fill <= FILL_MAX;
    end else if (shift_en && !rotate && (fill != FILL_MAX)) begin
      fill <= fill + CNT_W'(1);
    end
  end

  assign full = (fill == FILL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o <= '0;
      ind    <= '0;
    end else begin
      data_o <= out_en ? lane_view : '0;
      ind    <= stage_view;
    end
  end

endmodule

// File: tb/tb_shift_reg_bank.sv
// Directed bench for shift_reg_bank: word-level stage model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_shift_reg_bank;

  localparam int W = 4;
  localparam int D = 4;
  localparam int CW = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           shift_en = 1'b0;
  logic           dir = 1'b0;
  logic           rotate = 1'b0;
  logic           load = 1'b0;
  logic [W*D-1:0] load_data = '0;
  logic [W-1:0]   data_i = '0;
  logic           out_en = 1'b1;
  logic [W*D-1:0] data_o;
  logic [W*D-1:0] ind;
  logic [CW-1:0]  fill;
  logic           full;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  shift_reg_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .dir       (dir),
    .rotate    (rotate),
    .load      (load),
    .load_data (load_data),
    .data_i    (data_i),
    .out_en    (out_en),
    .data_o    (data_o),
    .ind       (ind),
    .fill      (fill),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Model: stage words m_st[s], expected registered views and fill level.
  logic [W-1:0]   m_st [D];
  logic [W*D-1:0] m_do;
  logic [W*D-1:0] m_ind;
  int             m_fill;

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] end_word;
    if (rst) begin
      for (int s = 0; s < D; s++) m_st[s] = '0;
      m_do = '0;
      m_ind = '0;
      m_fill = 0;
    end else begin
      for (int s = 0; s < D; s++) m_ind[W*s +: W] = m_st[s];
      for (int i = 0; i < W; i++)
        for (int j = 0; j < D; j++)
          m_do[D*i+j] = out_en ? m_st[j][i] : 1'b0;
      if (load) begin
        for (int s = 0; s < D; s++) m_st[s] = load_data[W*s +: W];
        m_fill = D;
      end else if (shift_en) begin
        if (!dir) begin
          end_word = m_st[D-1];
          for (int s = D - 1; s > 0; s--) m_st[s] = m_st[s-1];
          m_st[0] = rotate ? end_word : data_i;
        end else begin
          end_word = m_st[0];
          for (int s = 0; s < D - 1; s++) m_st[s] = m_st[s+1];
          m_st[D-1] = rotate ? end_word : data_i;
        end
        if (!rotate && m_fill < D) m_fill = m_fill + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_data_o", 64'(data_o), 64'(m_do));
      chk("cyc_ind", 64'(ind), 64'(m_ind));
      chk("cyc_fill", 64'(fill), 64'(m_fill));
      chk("cyc_full", 64'(full), 64'(m_fill == D));
    end
  end

  task automatic cyc(input logic ld, input logic [W*D-1:0] ldd, input logic se,
                     input logic dr, input logic rot, input logic [W-1:0] di,
                     input logic oe);
    load = ld;
    load_data = ldd;
    shift_en = se;
    dir = dr;
    rotate = rot;
    data_i = di;
    out_en = oe;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    chk("reset_fill", 64'(fill), 64'd0);
    rst = 1'b0;
    idle();

    // 1: async reset with nonzero stages
    cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle();
    chk("pre_reset_ind", 64'(ind), 64'h1234);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_data_o", 64'(data_o), 64'd0);
    chk("async_rst_ind", 64'(ind), 64'd0);
    chk("async_rst_fill", 64'(fill), 64'd0);
    chk("async_rst_full", 64'(full), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2: shift in 1,2,4,8 upward
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1);
    chk("fill_from_reset", 64'(fill), 64'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'h2, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b1);
    chk("fill_3", 64'(fill), 64'd3);
    chk("not_full_3", 64'(full), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'h8, 1'b1);
    chk("fill_4", 64'(fill), 64'd4);
    chk("full_4", 64'(full), 64'd1);
    idle();
    chk("shift_in_ind", 64'(ind), 64'h1248);

    // 3: saturation
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1);
    idle();
    chk("sat_ind", 64'(ind), 64'h48FF);
    chk("sat_fill", 64'(fill), 64'd4);

    // 4: rotate full circle
    cyc(1'b1, 16'h4321, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < D; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 4'h5, 1'b1);
    idle();
    chk("rotate_ind", 64'(ind), 64'h4321);
    chk("rotate_fill", 64'(fill), 64'd4);

    // 5: downward shift after load
    cyc(1'b1, 16'h4321, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1);
    idle();
    chk("down_ind", 64'(ind), 64'hA432);
    chk("down_data_o", 64'(data_o), 64'h84B2);

    // 6: load beats shift; out_en gating
    cyc(1'b1, 16'h9C3E, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("gated_data_o", 64'(data_o), 64'd0);
    chk("gated_ind", 64'(ind), 64'h9C3E);
    chk("prio_fill", 64'(fill), 64'd4);
    idle();
    chk("ungated_data_o", 64'(data_o), 64'hD53A);

    // direction toggling per cycle
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 4'h6, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1);
    idle();
    idle();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
